// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the memory stage: instruction codes, status
// codes, FSM states and the kind of memory access an instruction needs.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_STOP
  } state_t;

  typedef enum logic [1:0] {
    K_NONE,
    K_READ,
    K_WRITE
  } mem_kind_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Handshake and data-memory bus bundle for the memory stage controller.
// The slave modport is the controller's view; master is the surrounding pipeline.
interface mem_stage_ctrl_if #(parameter int W = 64) ();

  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_icode;
  logic [W-1:0] req_valE;
  logic [W-1:0] req_valA;
  logic [W-1:0] req_valP;
  logic [W-1:0] mem_addr;
  logic         mem_wEn;
  logic         mem_rEn;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         mem_err;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_valM;
  logic [2:0]   resp_stat;

  modport slave (
    input  req_valid, req_icode, req_valE, req_valA, req_valP,
    output req_ready,
    output mem_addr, mem_wEn, mem_rEn, mem_wdata,
    input  mem_rdata, mem_err,
    output resp_valid, resp_valM, resp_stat,
    input  resp_ready
  );

  modport master (
    output req_valid, req_icode, req_valE, req_valA, req_valP,
    input  req_ready,
    input  mem_addr, mem_wEn, mem_rEn, mem_wdata,
    output mem_rdata, mem_err,
    input  resp_valid, resp_valM, resp_stat,
    output resp_ready
  );

endinterface

// File: rtl/mem_addr_sel.sv
// Decodes an icode into the memory access it needs: address, write data,
// access kind, and whether the icode and the address are legal.
module mem_addr_sel
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = 1024,
  parameter int unsigned W          = 64
) (
  input  logic [3:0]   icode,
  input  logic [W-1:0] val_e,
  input  logic [W-1:0] val_a,
  input  logic [W-1:0] val_p,
  output logic [W-1:0] addr,
  output logic [W-1:0] wdata,
  output mem_kind_t    kind,
  output logic         icode_ok,
  output logic         addr_ok
);

  // Stack pops address through valA (old %rsp); everything else uses valE.
  always_comb begin
    addr     = '0;
    wdata    = '0;
    kind     = K_NONE;
    icode_ok = (icode <= I_POPQ);
    case (icode)
      I_RMMOVQ, I_PUSHQ: begin
        addr  = val_e;
        wdata = val_a;
        kind  = K_WRITE;
      end
      I_CALL: begin
        addr  = val_e;
        wdata = val_p;
        kind  = K_WRITE;
      end
      I_MRMOVQ: begin
        addr = val_e;
        kind = K_READ;
      end
      I_POPQ, I_RET: begin
        addr = val_a;
        kind = K_READ;
      end
      default: ;
    endcase
    addr_ok = (addr < W'(ADDR_LIMIT));
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Y86-64 memory stage controller: accepts one request, performs at most one
// data-memory access, returns valM/stat, and halts in STOP on any non-AOK status.
module mem_stage_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = 1024,
  parameter int unsigned W          = 64
) (
  input logic              clk,
  input logic              rst,
  mem_stage_ctrl_if.slave  bus
);

  state_t       state;
  logic [W-1:0] addr_q;
  logic [W-1:0] wdata_q;
  logic         wen_q;
  logic         ren_q;
  logic         is_read_q;
  logic         resp_valid_q;
  logic [W-1:0] valm_q;
  stat_t        stat_q;

  logic [W-1:0] sel_addr;
  logic [W-1:0] sel_wdata;
  mem_kind_t    sel_kind;
  logic         sel_icode_ok;
  logic         sel_addr_ok;

  mem_addr_sel #(
    .ADDR_LIMIT (ADDR_LIMIT),
    .W          (W)
  ) u_sel (
    .icode    (bus.req_icode),
    .val_e    (bus.req_valE),
    .val_a    (bus.req_valA),
    .val_p    (bus.req_valP),
    .addr     (sel_addr),
    .wdata    (sel_wdata),
    .kind     (sel_kind),
    .icode_ok (sel_icode_ok),
    .addr_ok  (sel_addr_ok)
  );

  // Decisions are taken on the accepting edge so the enables are already
  // registered and visible for the whole ISSUE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      is_read_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      valm_q       <= '0;
      stat_q       <= STAT_AOK;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (!sel_icode_ok) begin
              resp_valid_q <= 1'b1;
              valm_q       <= '0;
              stat_q       <= STAT_INS;
              state        <= S_RESP;
            end else if (sel_kind == K_NONE) begin
              resp_valid_q <= 1'b1;
              valm_q       <= '0;
              stat_q       <= (bus.req_icode == I_HALT) ? STAT_HLT : STAT_AOK;
              state        <= S_RESP;
            end else if (!sel_addr_ok) begin
              resp_valid_q <= 1'b1;
              valm_q       <= '0;
              stat_q       <= STAT_ADR;
              state        <= S_RESP;
            end else begin
              addr_q    <= sel_addr;
              wdata_q   <= (sel_kind == K_WRITE) ? sel_wdata : '0;
              wen_q     <= (sel_kind == K_WRITE);
              ren_q     <= (sel_kind == K_READ);
              is_read_q <= (sel_kind == K_READ);
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          addr_q  <= '0;
          wdata_q <= '0;
          wen_q   <= 1'b0;
          ren_q   <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          resp_valid_q <= 1'b1;
          if (bus.mem_err) begin
            valm_q <= '0;
            stat_q <= STAT_ADR;
          end else begin
            valm_q <= is_read_q ? bus.mem_rdata : '0;
            stat_q <= STAT_AOK;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            valm_q       <= '0;
            state        <= (stat_q == STAT_AOK) ? S_IDLE : S_STOP;
          end
        end
        S_STOP: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wEn    = wen_q;
  assign bus.mem_rEn    = ren_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_valM  = valm_q;
  assign bus.resp_stat  = stat_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl: a data-memory model drives the bus and
// a transaction-level reference model predicts each response.
module tb_mem_stage_ctrl;
  import y86_pkg::*;

  localparam int          W     = 64;
  localparam int unsigned LIMIT = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.W(W)) bus ();

  mem_stage_ctrl #(.ADDR_LIMIT(LIMIT), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Data memory model: reply (data + error) lands in the cycle after an enable.
  logic [63:0] store   [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];
  bit          inject_err = 1'b0;
  bit          pend       = 1'b0;
  bit          pend_err   = 1'b0;
  logic [63:0] pend_val   = '0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      pend          = 1'b0;
      bus.mem_rdata = {$urandom, $urandom};
      bus.mem_err   = 1'b0;
    end else begin
      if (pend) begin
        bus.mem_rdata = pend_val;
        bus.mem_err   = pend_err;
        pend          = 1'b0;
      end else begin
        bus.mem_rdata = {$urandom, $urandom};
        bus.mem_err   = 1'($urandom);
      end
      if (bus.mem_rEn || bus.mem_wEn) begin
        pend     = 1'b1;
        pend_err = inject_err;
        if (bus.mem_rEn)
          pend_val = store.exists(bus.mem_addr) ? store[bus.mem_addr] : 64'd0;
        else
          pend_val = {$urandom, $urandom};
        if (bus.mem_wEn && !inject_err)
          store[bus.mem_addr] = bus.mem_wdata;
      end
    end
  end

  // Reference model: what one instruction should do, from the Y86 rules.
  function automatic void refModel(
    input  logic [3:0]  ic,
    input  logic [63:0] e, a, p,
    input  bit          err,
    output int          kind,
    output logic [63:0] addr,
    output logic [63:0] wdata,
    output logic [63:0] valm,
    output logic [2:0]  stat,
    output int          lat
  );
    kind  = 0;
    addr  = 64'd0;
    wdata = 64'd0;
    valm  = 64'd0;
    lat   = 1;
    if (ic inside {4'h4, 4'hA, 4'h8}) kind = 2;
    if (ic inside {4'h5, 4'h9, 4'hB}) kind = 1;
    if (kind != 0) begin
      addr  = (ic inside {4'h9, 4'hB}) ? a : e;
      wdata = (ic == 4'h8) ? p : a;
    end
    if (ic > 4'hB)                stat = 3'd4;
    else if (kind == 0)           stat = (ic == 4'h0) ? 3'd2 : 3'd1;
    else if (addr >= 64'(LIMIT)) begin
      stat = 3'd3;
      kind = 0;
    end else begin
      lat  = 3;
      stat = err ? 3'd3 : 3'd1;
      if (kind == 1 && !err)
        valm = ref_mem.exists(addr) ? ref_mem[addr] : 64'd0;
    end
  endfunction

  task automatic driveIdle();
    bus.req_valid = 1'b0;
    bus.req_icode = 4'($urandom);
    bus.req_valE  = {$urandom, $urandom};
    bus.req_valA  = {$urandom, $urandom};
    bus.req_valP  = {$urandom, $urandom};
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_wen"},   64'(bus.mem_wEn), 64'd0);
    checkOutput({tag, "_ren"},   64'(bus.mem_rEn), 64'd0);
    checkOutput({tag, "_addr"},  bus.mem_addr, 64'd0);
    checkOutput({tag, "_wdata"}, bus.mem_wdata, 64'd0);
    checkOutput({tag, "_rvld"},  64'(bus.resp_valid), 64'd0);
    checkOutput({tag, "_valm"},  bus.resp_valM, 64'd0);
    checkOutput({tag, "_stat"},  64'(bus.resp_stat), 64'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_ready", 64'(bus.req_ready), 64'd1);
  endtask

  // Issue one request, follow it to its response, and consume it after `hold` cycles.
  task automatic applyStimulus(
    input  logic [3:0]  ic,
    input  logic [63:0] e, a, p,
    input  bit          err,
    input  int          hold,
    output logic [2:0]  stat_out
  );
    int kind, lat, n, wcnt, rcnt;
    logic [63:0] x_addr, x_wdata, x_valm, g_addr, g_wdata;
    logic [2:0]  x_stat;
    bit both, dirty;
    refModel(ic, e, a, p, err, kind, x_addr, x_wdata, x_valm, x_stat, lat);
    inject_err = err;
    @(negedge clk);
    checkOutput("req_ready", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_icode = ic;
    bus.req_valE  = e;
    bus.req_valA  = a;
    bus.req_valP  = p;
    @(negedge clk);
    driveIdle();
    n = 1; wcnt = 0; rcnt = 0; both = 1'b0; dirty = 1'b0;
    g_addr = '0; g_wdata = '0;
    while (!bus.resp_valid && n < 8) begin
      if (bus.mem_wEn) begin wcnt++; g_addr = bus.mem_addr; g_wdata = bus.mem_wdata; end
      if (bus.mem_rEn) begin rcnt++; g_addr = bus.mem_addr; end
      if (bus.mem_wEn && bus.mem_rEn) both = 1'b1;
      if (!bus.mem_wEn && !bus.mem_rEn && (bus.mem_addr != 0 || bus.mem_wdata != 0)) dirty = 1'b1;
      @(negedge clk);
      n++;
    end
    checkOutput("resp_latency", 64'(n), 64'(lat));
    checkOutput("wen_cycles", 64'(wcnt), (kind == 2) ? 64'd1 : 64'd0);
    checkOutput("ren_cycles", 64'(rcnt), (kind == 1) ? 64'd1 : 64'd0);
    checkOutput("both_enables", 64'(both), 64'd0);
    checkOutput("bus_idle_zero", 64'(dirty), 64'd0);
    if (kind != 0) checkOutput("mem_addr", g_addr, x_addr);
    if (kind == 2) checkOutput("mem_wdata", g_wdata, x_wdata);
    checkOutput("resp_enables_off", 64'({bus.mem_wEn, bus.mem_rEn}), 64'd0);
    checkOutput("resp_stat", 64'(bus.resp_stat), 64'(x_stat));
    checkOutput("resp_valM", bus.resp_valM, x_valm);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("hold_valid", 64'(bus.resp_valid), 64'd1);
      checkOutput("hold_stat", 64'(bus.resp_stat), 64'(x_stat));
      checkOutput("hold_valM", bus.resp_valM, x_valm);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    checkOutput("after_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("after_ready", 64'(bus.req_ready), (x_stat == 3'd1) ? 64'd1 : 64'd0);
    if (kind == 2 && x_stat == 3'd1) ref_mem[x_addr] = x_wdata;
    inject_err = 1'b0;
    stat_out = x_stat;
  endtask

  // A terminated controller must ignore requests and keep its final status.
  task automatic checkStop(input logic [2:0] x_stat, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bus.req_valid = 1'b1;
      bus.req_icode = I_MRMOVQ;
      bus.req_valE  = 64'(c * 8);
      @(negedge clk);
      checkOutput("stop_ready", 64'(bus.req_ready), 64'd0);
      checkOutput("stop_valid", 64'(bus.resp_valid), 64'd0);
      checkOutput("stop_enables", 64'({bus.mem_wEn, bus.mem_rEn}), 64'd0);
      checkOutput("stop_stat", 64'(bus.resp_stat), 64'(x_stat));
    end
    driveIdle();
  endtask

  task automatic resetDuringWait();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_icode = I_MRMOVQ;
    bus.req_valE  = 64'd101;
    @(negedge clk);
    driveIdle();
    checkOutput("rst_issue_ren", 64'(bus.mem_rEn), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetValues("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("rst_no_resp", 64'(bus.resp_valid), 64'd0);
      checkOutput("rst_ready", 64'(bus.req_ready), 64'd1);
    end
  endtask

  function automatic logic [63:0] randAddr();
    int sel = $urandom_range(0, 9);
    if (sel < 6)      return 64'($urandom_range(0, 1100));
    else if (sel < 8) return 64'($urandom_range(LIMIT - 2, LIMIT + 2));
    else              return {$urandom, $urandom};
  endfunction

  logic [2:0] st;

  initial begin
    driveIdle();
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    doReset();

    applyStimulus(I_RMMOVQ, 64'd101, 64'd3025, 64'd0, 1'b0, 1, st);
    applyStimulus(I_MRMOVQ, 64'd101, 64'd5, 64'd0, 1'b0, 2, st);
    applyStimulus(I_POPQ, 64'd409, 64'd401, 64'd0, 1'b0, 0, st);
    applyStimulus(I_CALL, 64'd393, 64'd12, 64'd77, 1'b0, 0, st);
    applyStimulus(I_RET, 64'd401, 64'd393, 64'd0, 1'b0, 1, st);
    applyStimulus(I_PUSHQ, 64'd1023, 64'd99, 64'd7, 1'b0, 0, st);
    applyStimulus(I_MRMOVQ, 64'd1023, 64'd0, 64'd0, 1'b0, 0, st);
    applyStimulus(I_NOP, 64'd5, 64'd6, 64'd7, 1'b0, 0, st);
    applyStimulus(I_OPQ, 64'd3000, 64'd6, 64'd7, 1'b0, 1, st);
    applyStimulus(I_IRMOVQ, 64'd1, 64'd2, 64'd3, 1'b0, 0, st);

    applyStimulus(I_MRMOVQ, 64'd2905, 64'd0, 64'd0, 1'b0, 1, st);
    checkStop(st, 4);
    doReset();
    applyStimulus(I_RMMOVQ, 64'd1024, 64'd1, 64'd0, 1'b0, 0, st);
    doReset();
    applyStimulus(I_MRMOVQ, 64'hFFFF_FFFF_FFFF_FF00, 64'd0, 64'd0, 1'b0, 0, st);
    doReset();
    applyStimulus(I_MRMOVQ, 64'd300, 64'd0, 64'd0, 1'b1, 1, st);
    checkStop(st, 2);
    doReset();
    applyStimulus(I_HALT, 64'd0, 64'd0, 64'd0, 1'b0, 1, st);
    checkStop(st, 3);
    doReset();
    applyStimulus(4'hC, 64'd0, 64'd0, 64'd0, 1'b0, 0, st);
    checkStop(st, 2);
    doReset();

    resetDuringWait();
    applyStimulus(I_MRMOVQ, 64'd101, 64'd0, 64'd0, 1'b0, 0, st);

    for (int t = 0; t < 200; t++) begin
      logic [3:0] ic;
      ic = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(4, 11)) : 4'($urandom);
      applyStimulus(ic, randAddr(), randAddr(), {$urandom, $urandom},
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3), st);
      if (st != 3'd1) begin
        checkStop(st, 1);
        doReset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no end expected end of stimulus");
    $fatal(1, "[TB] timeout");
  end

endmodule
